// File: rtl/kamus_pkg.sv
// kamus_pkg: shared L1D geometry constants and the cache controller state encoding.
package kamus_pkg;
  localparam int L1D_NUM_LINES      = 16;
  localparam int L1D_WORDS_PER_LINE = 4;
  localparam int L1D_TAG_W          = 24;
  typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_RSP, WRITE} l1d_state_e;
endpackage

// File: rtl/kamus_l1d_data_array.sv
// kamus_l1d_data_array: byte-enabled word storage, combinational read, synchronous write.
module kamus_l1d_data_array #(
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  localparam int DEPTH = 2 ** AW;
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/kamus_l1d.sv
// kamus_l1d: direct-mapped, write-through, no-write-allocate L1 data cache.
// Load hits return in the same cycle; misses refill the whole line one beat at a time.
module kamus_l1d
  import kamus_pkg::*;
#(
  parameter int NUM_LINES      = L1D_NUM_LINES,
  parameter int WORDS_PER_LINE = L1D_WORDS_PER_LINE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        l1d_req_i,
  input  logic        l1d_wr_en_i,
  input  logic [31:0] l1d_addr_i,
  input  logic [31:0] l1d_wr_data_i,
  input  logic [3:0]  l1d_be_i,
  input  logic        l1d_flush_i,
  output logic [31:0] l1d_rd_data_o,
  output logic        l1d_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int WRD_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W = WRD_W + 2;
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  l1d_state_e           state_q, state_d;
  logic [WRD_W-1:0]     beat_q, beat_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic                 tag_we;
  logic                 arr_we;
  logic [IDX_W+WRD_W-1:0] arr_waddr;
  logic [31:0]          arr_wdata, arr_rdata;
  logic [3:0]           arr_be;

  logic [IDX_W-1:0] idx;
  logic [WRD_W-1:0] wrd;
  logic [TAG_W-1:0] tag;
  logic             hit;

  assign idx = l1d_addr_i[OFF_W +: IDX_W];
  assign wrd = l1d_addr_i[2 +: WRD_W];
  assign tag = l1d_addr_i[31 -: TAG_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  kamus_l1d_data_array #(.AW(IDX_W + WRD_W)) u_data (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .raddr_i ({idx, wrd}),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    valid_d       = valid_q;
    tag_we        = 1'b0;
    arr_we        = 1'b0;
    arr_waddr     = {idx, wrd};
    arr_wdata     = l1d_wr_data_i;
    arr_be        = l1d_be_i;
    l1d_ready_o   = 1'b0;
    l1d_rd_data_o = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = l1d_addr_i;
    mem_wdata_o   = l1d_wr_data_i;
    mem_be_o      = l1d_be_i;
    case (state_q)
      IDLE: begin
        if (l1d_flush_i) valid_d = '0;
        else if (!l1d_req_i) l1d_ready_o = 1'b1;
        else if (l1d_wr_en_i) state_d = WRITE;
        else if (hit) begin
          l1d_ready_o   = 1'b1;
          l1d_rd_data_o = arr_rdata;
        end else begin
          valid_d[idx] = 1'b0;
          state_d      = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {l1d_addr_i[31:OFF_W], beat_q, 2'b00};
        mem_be_o   = 4'hF;
        state_d    = mem_gnt_i ? REFILL_RSP : REFILL_REQ;
      end
      REFILL_RSP: begin
        if (mem_rvalid_i) begin
          arr_we    = 1'b1;
          arr_waddr = {idx, beat_q};
          arr_wdata = mem_rdata_i;
          arr_be    = 4'hF;
          beat_d    = beat_q + 1'b1;
          state_d   = (&beat_q) ? IDLE : REFILL_REQ;
          if (&beat_q) begin
            valid_d[idx] = 1'b1;
            tag_we       = 1'b1;
          end
        end
      end
      WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        l1d_ready_o = mem_gnt_i;
        arr_we      = mem_gnt_i && hit;
        state_d     = mem_gnt_i ? IDLE : WRITE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (tag_we) tag_q[idx] <= tag;
  end
endmodule

// File: tb/tb_kamus_l1d.sv
// tb_kamus_l1d: scoreboard bench for kamus_l1d with a behavioural backing memory and cache model.
module tb_kamus_l1d;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, wr_en = 1'b0, flush = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rd_data, mem_addr, mem_wdata, rdata = '0;
  logic        ready, mem_req, mem_we, gnt = 1'b0, rvalid = 1'b0;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  kamus_l1d dut (
    .clk_i(clk), .rst_ni(rst_n),
    .l1d_req_i(req), .l1d_wr_en_i(wr_en), .l1d_addr_i(addr),
    .l1d_wr_data_i(wdata), .l1d_be_i(be), .l1d_flush_i(flush),
    .l1d_rd_data_o(rd_data), .l1d_ready_o(ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          reads;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0, miscompares = 0;
  logic [31:0] bmem    [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  bit   [15:0] mvalid = '0;
  logic [23:0] mtag [16];

  int gnt_dly = 0, rv_dly = 0, rv_total = 0;
  bit rand_dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seed_word(input logic [29:0] w);
    return {w[13:0], 2'b10, w[15:0]} ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] bm_rd(input logic [31:0] a);
    return bmem.exists(a[31:2]) ? bmem[a[31:2]] : seed_word(a[31:2]);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : seed_word(a[31:2]);
  endfunction

  // Backing memory: grants after a configurable wait, returns read data later.
  initial begin
    bit          pend = 0;
    int          wcnt = 0, gwait = -1, rcnt = 0;
    logic [31:0] paddr = '0, w;
    forever begin
      @(posedge clk); #2;
      gnt = 1'b0; rvalid = 1'b0;
      if (!rst_n) begin
        pend = 0; wcnt = 0; gwait = -1;
      end else if (pend) begin
        if (rcnt == 0) begin
          rvalid = 1'b1; rdata = bm_rd(paddr); pend = 0; rv_total++;
        end else rcnt--;
      end else if (mem_req) begin
        if (gwait < 0) gwait = rand_dly ? int'($urandom_range(0, 2)) : gnt_dly;
        if (wcnt >= gwait) begin
          gnt = 1'b1; wcnt = 0; gwait = -1;
          if (mem_we) begin
            w = bm_rd(mem_addr);
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            bmem[mem_addr[31:2]] = w;
          end else begin
            pend = 1; paddr = mem_addr;
            rcnt = rand_dly ? int'($urandom_range(0, 2)) : rv_dly;
          end
        end else wcnt++;
      end
    end
  end

  // Monitor: pops one expectation per completed access and checks bus behaviour.
  initial begin
    int          rd_cnt = 0, wr_cnt = 0;
    bit          out_rd = 0;
    logic [31:0] wa = '0, wd = '0;
    logic [3:0]  wb = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cnt = 0; wr_cnt = 0; out_rd = 0;
      end else begin
        if (out_rd) chk("one_outstanding", 32'(mem_req), 32'd0);
        if (rvalid) out_rd = 0;
        if (gnt && mem_req) begin
          if (mem_we) begin
            wr_cnt++; wa = mem_addr; wd = mem_wdata; wb = mem_be;
          end else begin
            rd_cnt++; out_rd = 1;
          end
        end
        if (req && ready) begin
          chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (!e.wr) begin
              chk("ld_data", rd_data, e.data);
              chk("ld_reads", 32'(rd_cnt), 32'(e.reads));
              chk("ld_writes", 32'(wr_cnt), 32'd0);
            end else begin
              chk("st_writes", 32'(wr_cnt), 32'd1);
              chk("st_reads", 32'(rd_cnt), 32'd0);
              chk("st_addr", wa, e.addr);
              chk("st_wdata", wd, e.data);
              chk("st_be", 32'(wb), 32'(e.be));
              chk("st_rdata0", rd_data, 32'd0);
            end
          end
          rd_cnt = 0; wr_cnt = 0;
        end else chk("rdata_idle0", rd_data, 32'd0);
      end
    end
  end

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit fl, output int stalls, output logic [31:0] rd);
    exp_t        e;
    logic [3:0]  ix = a[7:4];
    logic [31:0] nw;
    bit          hit;
    if (fl) mvalid = '0;
    hit = mvalid[ix] && (mtag[ix] == a[31:8]);
    e.wr = w; e.addr = a; e.be = b; e.reads = 0;
    if (w) begin
      nw = ref_rd(a);
      for (int k = 0; k < 4; k++) if (b[k]) nw[8*k +: 8] = d[8*k +: 8];
      ref_mem[a[31:2]] = nw;
      e.data = d;
    end else begin
      e.data = ref_rd(a);
      e.reads = hit ? 0 : 4;
      mvalid[ix] = 1'b1; mtag[ix] = a[31:8];
    end
    @(posedge clk); #1;
    req = 1'b1; wr_en = w; addr = a; wdata = d; be = b; flush = fl;
    exp_q.push_back(e);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (fl && stalls == 0) chk("flush_ready0", 32'(ready), 32'd0);
      if (ready) break;
      stalls++;
      if (stalls > 400) begin
        vectors++; miscompares++;
        $display("FAIL timeout: no ready after %0d cycles, expected completion", stalls);
        break;
      end
      @(posedge clk); #1;
      flush = 1'b0;
    end
    rd = rd_data;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_memreq", 32'(mem_req), 32'd0);
    end
  endtask

  task automatic flush_only();
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b1;
    mvalid = '0;
    @(negedge clk);
    chk("flush_ready0", 32'(ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st, base;
    logic [31:0] rd, a;
    int          r;
    bmem[30'h4] = 32'h0000_00A0; bmem[30'h5] = 32'h00A1_0000;
    bmem[30'h6] = 32'h0000_00A2; bmem[30'h7] = 32'h0000_00A3;
    ref_mem[30'h4] = 32'h0000_00A0; ref_mem[30'h5] = 32'h00A1_0000;
    ref_mem[30'h6] = 32'h0000_00A2; ref_mem[30'h7] = 32'h0000_00A3;
    repeat (3) @(negedge clk);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_memwe", 32'(mem_we), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_memreq_after", 32'(mem_req), 32'd0);
    chk("rst_rdata", rd_data, 32'd0);

    gnt_dly = 1; rv_dly = 1;
    access(0, 32'h10, '0, '0, 0, st, rd);
    chk("miss_stall", 32'(st), 32'd17);
    chk("miss_rdata", rd, 32'h0000_00A0);
    access(0, 32'h18, '0, '0, 0, st, rd);
    chk("hit_stall", 32'(st), 32'd0);
    chk("hit_rdata", rd, 32'h0000_00A2);

    gnt_dly = 2;
    access(1, 32'h14, 32'h0000_BEEF, 4'b0011, 0, st, rd);
    chk("st_stall", 32'(st), 32'd3);
    chk("bmem_14", bm_rd(32'h14), 32'h00A1_BEEF);
    access(0, 32'h14, '0, '0, 0, st, rd);
    chk("st_hit_stall", 32'(st), 32'd0);
    chk("st_hit_rdata", rd, 32'h00A1_BEEF);

    gnt_dly = 0; rv_dly = 0;
    access(0, 32'h110, '0, '0, 0, st, rd);
    chk("conflict_stall", 32'(st), 32'd9);
    access(0, 32'h10, '0, '0, 0, st, rd);
    chk("evicted_stall", 32'(st), 32'd9);
    access(0, 32'h10, '0, '0, 1, st, rd);
    chk("flush_load_stall", 32'(st), 32'd10);
    chk("flush_load_rdata", rd, 32'h0000_00A0);
    idle(2);

    flush_only();
    @(posedge clk); #1;
    req = 1'b1; wr_en = 1'b0; addr = 32'h300;
    base = rv_total;
    for (int i = 0; i < 100 && rv_total - base < 2; i++) @(negedge clk);
    @(negedge clk);
    chk("abort_memreq_pre", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_memreq", 32'(mem_req), 32'd0);
    chk("abort_memwe", 32'(mem_we), 32'd0);
    req = 1'b0;
    mvalid = '0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    access(0, 32'h300, '0, '0, 0, st, rd);
    chk("abort_remiss_stall", 32'(st), 32'd9);

    rand_dly = 1;
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
      r = int'($urandom_range(0, 99));
      if (r < 3) flush_only();
      if (r >= 90) idle(int'($urandom_range(1, 3)));
      access(r < 30, a, $urandom, 4'($urandom_range(1, 15)), r >= 95, st, rd);
    end
    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
